// File: rtl/rggen_rtl_pkg.sv
// Shared types and helpers for the rggen external-bus exporter.
//   rggen_status          - two-bit response status (OKAY/EXOKAY/SLVERR/DECERR)
//   rggen_exporter_state  - exporter FSM states (IDLE/BUSY/RESP)
//   rggen_counter_fits()  - true when a counter of 'width' bits can hold 'limit'
package rggen_rtl_pkg;

  typedef enum logic [1:0] {
    RGGEN_OKAY   = 2'b00,
    RGGEN_EXOKAY = 2'b01,
    RGGEN_SLVERR = 2'b10,
    RGGEN_DECERR = 2'b11
  } rggen_status;

  typedef enum logic [1:0] {
    EXPORTER_IDLE = 2'b00,
    EXPORTER_BUSY = 2'b01,
    EXPORTER_RESP = 2'b10
  } rggen_exporter_state;

  // A limit of 0 (timeout disabled) fits any width.
  function automatic bit rggen_counter_fits(int width, int limit);
    if (limit <= 0) return 1'b1;
    return ($clog2(limit + 1) <= width);
  endfunction

endpackage

// File: rtl/rggen_timeout_counter.sv
// Saturating busy-cycle counter with an expiry flag.
//   clk, rst  - clock, synchronous active-high reset
//   clear     - zero the count (takes priority over enable)
//   enable    - count one cycle (holds at all-ones, never wraps)
//   expired   - count has reached LIMIT-1; always 0 when LIMIT == 0
// Parameters: WIDTH (count width), LIMIT (cycles to expiry, 0 = never).
module rggen_timeout_counter #(
  parameter int WIDTH = 8,
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [WIDTH-1:0] LAST = (LIMIT > 0) ? WIDTH'(LIMIT - 1) : '0;

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != '1)) begin
      count <= count + WIDTH'(1);
    end
  end

  // Expiry is flagged on the last allowed cycle itself, so the owner can
  // leave on that same edge when its response is still missing.
  assign expired = (LIMIT > 0) && (count == LAST);

endmodule

// File: rtl/rggen_bus_exporter_tmo.sv
// External-register bus exporter with response timeout.
// Bridges one decoded register window from the local command bus to an
// external valid/ready bus and returns a registered one-cycle response.
//   clk, rst                  - clock, synchronous active-high reset
//   i_valid/i_select/i_write/i_read/i_address/i_strobe/i_write_data
//                             - local command from the address decoder
//   o_ready/o_read_data/o_status - one-cycle response to the response mux
//   o_valid/o_write/o_read/o_address/o_strobe/o_write_data
//                             - external request, held stable while o_valid
//   i_ready/i_read_data/i_status - external response
//   o_timeout                 - pulses with o_ready when the response timed out
//   o_error_count             - only with RGGEN_BUS_EXPORTER_ERROR_COUNT_EN:
//                               saturating count of SLVERR/DECERR responses
// Handshake: a local command is accepted in IDLE when i_valid & i_select &
// (i_write | i_read); the external side completes a request in the first
// cycle where o_valid & i_ready are both high; o_ready is a single-cycle
// strobe and the upstream keeps i_valid high until it sees it.
module rggen_bus_exporter_tmo
  import rggen_rtl_pkg::*;
#(
  parameter int                             DATA_WIDTH             = 32,
  parameter int                             LOCAL_ADDRESS_WIDTH    = 8,
  parameter int                             EXTERNAL_ADDRESS_WIDTH = 7,
  parameter logic [LOCAL_ADDRESS_WIDTH-1:0] START_ADDRESS          = '0,
  parameter int                             TIMEOUT_CYCLES         = 255,
  parameter int                             COUNTER_WIDTH          = 8
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              i_valid,
  input  logic                              i_select,
  input  logic                              i_write,
  input  logic                              i_read,
  input  logic [LOCAL_ADDRESS_WIDTH-1:0]    i_address,
  input  logic [DATA_WIDTH/8-1:0]           i_strobe,
  input  logic [DATA_WIDTH-1:0]             i_write_data,
  output logic                              o_ready,
  output logic [DATA_WIDTH-1:0]             o_read_data,
  output logic [1:0]                        o_status,
  output logic                              o_valid,
  output logic                              o_write,
  output logic                              o_read,
  output logic [EXTERNAL_ADDRESS_WIDTH-1:0] o_address,
  output logic [DATA_WIDTH/8-1:0]           o_strobe,
  output logic [DATA_WIDTH-1:0]             o_write_data,
  input  logic                              i_ready,
  input  logic [DATA_WIDTH-1:0]             i_read_data,
  input  logic [1:0]                        i_status,
`ifdef RGGEN_BUS_EXPORTER_ERROR_COUNT_EN
  output logic [7:0]                        o_error_count,
`endif
  output logic                              o_timeout
);

  if (!rggen_counter_fits(COUNTER_WIDTH, TIMEOUT_CYCLES)) begin : g_bad_counter_width
    $error("COUNTER_WIDTH is too narrow for TIMEOUT_CYCLES");
  end

  rggen_exporter_state state_q, state_d;

  logic                              cmd_accept;
  logic                              resp_ack;
  logic                              timeout_hit;
  logic                              counter_expired;
  logic                              write_q;
  logic                              read_q;
  logic [EXTERNAL_ADDRESS_WIDTH-1:0] address_q;
  logic [DATA_WIDTH/8-1:0]           strobe_q;
  logic [DATA_WIDTH-1:0]             write_data_q;
  logic [DATA_WIDTH-1:0]             resp_data_q;
  logic [1:0]                        resp_status_q;
  logic                              timeout_q;

  assign cmd_accept  = (state_q == EXPORTER_IDLE) && i_valid && i_select && (i_write || i_read);
  assign resp_ack    = (state_q == EXPORTER_BUSY) && i_ready;
  // A response arriving on the expiry cycle wins over the timeout.
  assign timeout_hit = (state_q == EXPORTER_BUSY) && !i_ready && counter_expired;

  always_comb begin
    state_d = state_q;
    case (state_q)
      EXPORTER_IDLE: if (cmd_accept)              state_d = EXPORTER_BUSY;
      EXPORTER_BUSY: if (resp_ack || timeout_hit) state_d = EXPORTER_RESP;
      EXPORTER_RESP:                              state_d = EXPORTER_IDLE;
      default:                                    state_d = EXPORTER_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= EXPORTER_IDLE;
    else     state_q <= state_d;
  end

  // Request payload is captured once at acceptance and held through BUSY.
  always_ff @(posedge clk) begin
    if (rst) begin
      write_q      <= 1'b0;
      read_q       <= 1'b0;
      address_q    <= '0;
      strobe_q     <= '0;
      write_data_q <= '0;
    end else if (cmd_accept) begin
      write_q      <= i_write;
      read_q       <= i_read;
      address_q    <= EXTERNAL_ADDRESS_WIDTH'(i_address - START_ADDRESS);
      strobe_q     <= i_strobe;
      write_data_q <= i_write_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      resp_data_q   <= '0;
      resp_status_q <= '0;
      timeout_q     <= 1'b0;
    end else if (resp_ack) begin
      resp_data_q   <= write_q ? '0 : i_read_data;
      resp_status_q <= i_status;
      timeout_q     <= 1'b0;
    end else if (timeout_hit) begin
      resp_data_q   <= '0;
      resp_status_q <= RGGEN_SLVERR;
      timeout_q     <= 1'b1;
    end
  end

  rggen_timeout_counter #(
    .WIDTH (COUNTER_WIDTH),
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout_counter (
    .clk     (clk),
    .rst     (rst),
    .clear   (cmd_accept),
    .enable  ((state_q == EXPORTER_BUSY) && !i_ready),
    .expired (counter_expired)
  );

`ifdef RGGEN_BUS_EXPORTER_ERROR_COUNT_EN
  logic [7:0] error_count_q;

  // Status bit 1 set means SLVERR or DECERR (timeouts report SLVERR).
  always_ff @(posedge clk) begin
    if (rst) begin
      error_count_q <= '0;
    end else if ((state_q == EXPORTER_RESP) && resp_status_q[1] && (error_count_q != 8'hFF)) begin
      error_count_q <= error_count_q + 8'd1;
    end
  end

  assign o_error_count = error_count_q;
`endif

  assign o_valid      = (state_q == EXPORTER_BUSY);
  assign o_write      = write_q;
  assign o_read       = read_q;
  assign o_address    = address_q;
  assign o_strobe     = strobe_q;
  assign o_write_data = write_data_q;

  assign o_ready      = (state_q == EXPORTER_RESP);
  assign o_read_data  = o_ready ? resp_data_q : '0;
  assign o_status     = o_ready ? resp_status_q : 2'b00;
  assign o_timeout    = o_ready && timeout_q;

endmodule

// File: tb/tb_rggen_bus_exporter_tmo.sv
// Bench for rggen_bus_exporter_tmo. Two instances share the local and
// external input buses: dut_a uses the default timeout (255 cycles), dut_b
// uses a 4-cycle timeout. Each is addressed through its own i_select, so the
// unselected one stays idle. Inputs change on the falling edge and outputs
// are sampled on the falling edge. Build with RGGEN_BUS_EXPORTER_ERROR_COUNT_EN
// defined to include the error-counter scenario.
module tb_rggen_bus_exporter_tmo;

  localparam int DW  = 32;
  localparam int LAW = 8;
  localparam int EAW = 7;
  localparam int SW  = DW / 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic           i_valid, sel_a, sel_b, i_write, i_read;
  logic [LAW-1:0] i_address;
  logic [SW-1:0]  i_strobe;
  logic [DW-1:0]  i_write_data;
  logic           ext_ready;
  logic [DW-1:0]  ext_read_data;
  logic [1:0]     ext_status;

  logic           a_ready, a_valid, a_write, a_read, a_timeout;
  logic [DW-1:0]  a_read_data, a_write_data;
  logic [1:0]     a_status;
  logic [EAW-1:0] a_address;
  logic [SW-1:0]  a_strobe;

  logic           b_ready, b_valid, b_write, b_read, b_timeout;
  logic [DW-1:0]  b_read_data, b_write_data;
  logic [1:0]     b_status;
  logic [EAW-1:0] b_address;
  logic [SW-1:0]  b_strobe;

`ifdef RGGEN_BUS_EXPORTER_ERROR_COUNT_EN
  logic [7:0]     a_error_count, b_error_count;
`endif

  int errors = 0;
  int checks = 0;

  rggen_bus_exporter_tmo #(
    .DATA_WIDTH(DW), .LOCAL_ADDRESS_WIDTH(LAW), .EXTERNAL_ADDRESS_WIDTH(EAW),
    .START_ADDRESS(8'h80), .TIMEOUT_CYCLES(255), .COUNTER_WIDTH(8)
  ) dut_a (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_select(sel_a),
    .i_write(i_write), .i_read(i_read), .i_address(i_address),
    .i_strobe(i_strobe), .i_write_data(i_write_data),
    .o_ready(a_ready), .o_read_data(a_read_data), .o_status(a_status),
    .o_valid(a_valid), .o_write(a_write), .o_read(a_read),
    .o_address(a_address), .o_strobe(a_strobe), .o_write_data(a_write_data),
    .i_ready(ext_ready), .i_read_data(ext_read_data), .i_status(ext_status),
`ifdef RGGEN_BUS_EXPORTER_ERROR_COUNT_EN
    .o_error_count(a_error_count),
`endif
    .o_timeout(a_timeout)
  );

  rggen_bus_exporter_tmo #(
    .DATA_WIDTH(DW), .LOCAL_ADDRESS_WIDTH(LAW), .EXTERNAL_ADDRESS_WIDTH(EAW),
    .START_ADDRESS(8'h80), .TIMEOUT_CYCLES(4), .COUNTER_WIDTH(8)
  ) dut_b (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_select(sel_b),
    .i_write(i_write), .i_read(i_read), .i_address(i_address),
    .i_strobe(i_strobe), .i_write_data(i_write_data),
    .o_ready(b_ready), .o_read_data(b_read_data), .o_status(b_status),
    .o_valid(b_valid), .o_write(b_write), .o_read(b_read),
    .o_address(b_address), .o_strobe(b_strobe), .o_write_data(b_write_data),
    .i_ready(ext_ready), .i_read_data(ext_read_data), .i_status(ext_status),
`ifdef RGGEN_BUS_EXPORTER_ERROR_COUNT_EN
    .o_error_count(b_error_count),
`endif
    .o_timeout(b_timeout)
  );

  // ---------------- driver tasks ----------------
  task automatic set_cmd(input logic a, input logic b, input logic wr, input logic rd,
                         input logic [LAW-1:0] addr, input logic [SW-1:0] strb,
                         input logic [DW-1:0] wdata);
    i_valid = 1'b1; sel_a = a; sel_b = b; i_write = wr; i_read = rd;
    i_address = addr; i_strobe = strb; i_write_data = wdata;
  endtask

  task automatic clear_cmd();
    i_valid = 1'b0; sel_a = 1'b0; sel_b = 1'b0; i_write = 1'b0; i_read = 1'b0;
    i_address = '0; i_strobe = '0; i_write_data = '0;
  endtask

  task automatic set_ext(input logic rdy, input logic [DW-1:0] d, input logic [1:0] s);
    ext_ready = rdy; ext_read_data = d; ext_status = s;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    clear_cmd();
    set_ext(1'b0, '0, 2'b00);
    repeat (3) @(negedge clk);
    checks++;
    if ({a_valid, a_write, a_read, a_address, a_strobe, a_write_data,
         a_ready, a_read_data, a_status, a_timeout} !== '0) begin
      errors++;
      $display("FAIL reset_a: got valid=%b ready=%b addr=%h wdata=%h rdata=%h status=%b tmo=%b, expected all 0",
               a_valid, a_ready, a_address, a_write_data, a_read_data, a_status, a_timeout);
    end
    checks++;
    if ({b_valid, b_write, b_read, b_address, b_strobe, b_write_data,
         b_ready, b_read_data, b_status, b_timeout} !== '0) begin
      errors++;
      $display("FAIL reset_b: got valid=%b ready=%b addr=%h wdata=%h rdata=%h status=%b tmo=%b, expected all 0",
               b_valid, b_ready, b_address, b_write_data, b_read_data, b_status, b_timeout);
    end
    rst = 1'b0;
  endtask

  // Accept cycle counts as cycle 1; o_valid in cycle 2, o_ready in cycle 3.
  task automatic test_read();
    set_cmd(1'b1, 1'b0, 1'b0, 1'b1, 8'h84, 4'hF, '0);
    @(negedge clk);
    checks++;
    if ({a_valid, a_read, a_write, a_address, a_ready} !== {1'b1, 1'b1, 1'b0, 7'h04, 1'b0}) begin
      errors++;
      $display("FAIL read_request: got valid=%b read=%b write=%b addr=%h ready=%b, expected 1 1 0 04 0",
               a_valid, a_read, a_write, a_address, a_ready);
    end
    set_ext(1'b1, 32'hDEADBEEF, 2'b00);
    @(negedge clk);
    checks++;
    if (a_ready !== 1'b1) begin
      errors++;
      $display("FAIL read_latency: o_ready=%b in cycle 3, expected 1", a_ready);
    end
    checks++;
    if ({a_read_data, a_status, a_valid, a_timeout} !== {32'hDEADBEEF, 2'b00, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL read_response: got rdata=%h status=%b valid=%b tmo=%b, expected deadbeef 00 0 0",
               a_read_data, a_status, a_valid, a_timeout);
    end
    set_ext(1'b0, '0, 2'b00);
    @(negedge clk);
    checks++;
    if ({a_ready, a_valid, a_read_data, a_status} !== '0) begin
      errors++;
      $display("FAIL read_no_reaccept: got ready=%b valid=%b rdata=%h status=%b, expected all 0",
               a_ready, a_valid, a_read_data, a_status);
    end
    clear_cmd();
  endtask

  task automatic test_write();
    set_cmd(1'b1, 1'b0, 1'b1, 1'b0, 8'h88, 4'b0011, 32'h12345678);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      // Disturb the local bus to prove the external payload is registered.
      if (k == 1) begin
        i_write_data = 32'hFFFF_FFFF;
        i_strobe     = 4'b1100;
      end
      checks++;
      if ({a_valid, a_write, a_read, a_address, a_strobe, a_write_data, a_ready} !==
          {1'b1, 1'b1, 1'b0, 7'h08, 4'b0011, 32'h12345678, 1'b0}) begin
        errors++;
        $display("FAIL write_hold cycle %0d: got valid=%b wr=%b rd=%b addr=%h strb=%b wdata=%h ready=%b, expected 1 1 0 08 0011 12345678 0",
                 k, a_valid, a_write, a_read, a_address, a_strobe, a_write_data, a_ready);
      end
      if (k == 5) set_ext(1'b1, 32'hCAFEF00D, 2'b10);
    end
    @(negedge clk);
    checks++;
    if ({a_ready, a_read_data, a_status, a_valid, a_timeout} !== {1'b1, 32'h0, 2'b10, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL write_response: got ready=%b rdata=%h status=%b valid=%b tmo=%b, expected 1 00000000 10 0 0",
               a_ready, a_read_data, a_status, a_valid, a_timeout);
    end
    set_ext(1'b0, '0, 2'b00);
    @(negedge clk);
    clear_cmd();
  endtask

  task automatic test_timeout();
    set_cmd(1'b0, 1'b1, 1'b0, 1'b1, 8'h90, 4'hF, '0);
    set_ext(1'b0, 32'hDEADBEEF, 2'b00);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      checks++;
      if ({b_valid, b_ready, b_timeout, b_address} !== {1'b1, 1'b0, 1'b0, 7'h10}) begin
        errors++;
        $display("FAIL timeout_busy cycle %0d: got valid=%b ready=%b tmo=%b addr=%h, expected 1 0 0 10",
                 k, b_valid, b_ready, b_timeout, b_address);
      end
    end
    @(negedge clk);
    checks++;
    if ({b_ready, b_timeout, b_status, b_read_data, b_valid} !== {1'b1, 1'b1, 2'b10, 32'h0, 1'b0}) begin
      errors++;
      $display("FAIL timeout_response: got ready=%b tmo=%b status=%b rdata=%h valid=%b, expected 1 1 10 00000000 0",
               b_ready, b_timeout, b_status, b_read_data, b_valid);
    end
    set_ext(1'b1, 32'h11112222, 2'b00);  // late response must be dropped
    @(negedge clk);
    checks++;
    if ({b_ready, b_valid, b_timeout} !== 3'b000) begin
      errors++;
      $display("FAIL timeout_late_ready: got ready=%b valid=%b tmo=%b, expected 0 0 0",
               b_ready, b_valid, b_timeout);
    end
    set_ext(1'b0, '0, 2'b00);
    clear_cmd();
    @(negedge clk);
    checks++;
    if ({b_ready, b_valid, b_read_data} !== '0) begin
      errors++;
      $display("FAIL timeout_idle: got ready=%b valid=%b rdata=%h, expected 0 0 00000000",
               b_ready, b_valid, b_read_data);
    end
  endtask

  task automatic test_ready_vs_timeout();
    set_cmd(1'b0, 1'b1, 1'b0, 1'b1, 8'h8C, 4'hF, '0);
    set_ext(1'b0, '0, 2'b00);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      checks++;
      if ({b_valid, b_timeout} !== 2'b10) begin
        errors++;
        $display("FAIL race_busy cycle %0d: got valid=%b tmo=%b, expected 1 0", k, b_valid, b_timeout);
      end
      if (k == 4) set_ext(1'b1, 32'hA5A5A5A5, 2'b01);
    end
    @(negedge clk);
    checks++;
    if ({b_ready, b_timeout, b_read_data, b_status} !== {1'b1, 1'b0, 32'hA5A5A5A5, 2'b01}) begin
      errors++;
      $display("FAIL race_response: got ready=%b tmo=%b rdata=%h status=%b, expected 1 0 a5a5a5a5 01",
               b_ready, b_timeout, b_read_data, b_status);
    end
    set_ext(1'b0, '0, 2'b00);
    @(negedge clk);
    clear_cmd();
  endtask

  task automatic test_mid_reset();
    set_cmd(1'b1, 1'b0, 1'b0, 1'b1, 8'h84, 4'hF, '0);
    set_ext(1'b0, '0, 2'b00);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (a_valid !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset_busy: o_valid=%b, expected 1", a_valid);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({a_valid, a_ready} !== 2'b00) begin
      errors++;
      $display("FAIL mid_reset_abort: got valid=%b ready=%b, expected 0 0", a_valid, a_ready);
    end
    rst = 1'b0;
    clear_cmd();
    @(negedge clk);
    checks++;
    if ({a_valid, a_ready} !== 2'b00) begin
      errors++;
      $display("FAIL mid_reset_no_resp: got valid=%b ready=%b, expected 0 0", a_valid, a_ready);
    end
    set_cmd(1'b1, 1'b0, 1'b0, 1'b1, 8'h81, 4'hF, '0);
    @(negedge clk);
    checks++;
    if ({a_valid, a_address} !== {1'b1, 7'h01}) begin
      errors++;
      $display("FAIL mid_reset_next_req: got valid=%b addr=%h, expected 1 01", a_valid, a_address);
    end
    set_ext(1'b1, 32'h0BADF00D, 2'b00);
    @(negedge clk);
    checks++;
    if ({a_ready, a_read_data, a_status} !== {1'b1, 32'h0BADF00D, 2'b00}) begin
      errors++;
      $display("FAIL mid_reset_next_resp: got ready=%b rdata=%h status=%b, expected 1 0badf00d 00",
               a_ready, a_read_data, a_status);
    end
    set_ext(1'b0, '0, 2'b00);
    @(negedge clk);
    clear_cmd();
  endtask

  task automatic test_ignored();
    set_cmd(1'b0, 1'b0, 1'b0, 1'b1, 8'h84, 4'hF, '0);  // not selected
    @(negedge clk);
    checks++;
    if ({a_valid, b_valid} !== 2'b00) begin
      errors++;
      $display("FAIL ignore_unselected: got a_valid=%b b_valid=%b, expected 0 0", a_valid, b_valid);
    end
    set_cmd(1'b1, 1'b0, 1'b0, 1'b0, 8'h84, 4'hF, '0);  // neither read nor write
    @(negedge clk);
    checks++;
    if (a_valid !== 1'b0) begin
      errors++;
      $display("FAIL ignore_no_op: got valid=%b, expected 0", a_valid);
    end
    clear_cmd();
  endtask

  // Commands presented back to back, including the window base and top.
  task automatic test_back_to_back();
    logic [DW-1:0]  exp_q[$];
    logic [LAW-1:0] addrs [2] = '{8'h80, 8'hFF};
    logic [EAW-1:0] exp_addr [2] = '{7'h00, 7'h7F};
    logic [DW-1:0]  datas [2] = '{32'h01020304, 32'h89ABCDEF};
    logic [DW-1:0]  exp_data;
    for (int i = 0; i < 2; i++) exp_q.push_back(datas[i]);
    for (int i = 0; i < 2; i++) begin
      set_cmd(1'b1, 1'b0, 1'b0, 1'b1, addrs[i], 4'hF, '0);
      set_ext(1'b0, '0, 2'b00);
      @(negedge clk);
      checks++;
      if ({a_valid, a_address} !== {1'b1, exp_addr[i]}) begin
        errors++;
        $display("FAIL b2b_addr %0d: got valid=%b addr=%h, expected 1 %h", i, a_valid, a_address, exp_addr[i]);
      end
      set_ext(1'b1, datas[i], 2'b00);
      @(negedge clk);
      exp_data = exp_q.pop_front();
      checks++;
      if ({a_ready, a_read_data} !== {1'b1, exp_data}) begin
        errors++;
        $display("FAIL b2b_resp %0d: got ready=%b rdata=%h, expected 1 %h", i, a_ready, a_read_data, exp_data);
      end
      set_ext(1'b0, '0, 2'b00);
      @(negedge clk);
    end
    clear_cmd();
  endtask

`ifdef RGGEN_BUS_EXPORTER_ERROR_COUNT_EN
  task automatic test_error_count();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (b_error_count !== 8'd0) begin
      errors++;
      $display("FAIL err_count_reset: got %0d, expected 0", b_error_count);
    end
    for (int n = 0; n < 3; n++) begin
      set_cmd(1'b0, 1'b1, 1'b0, 1'b1, 8'h84, 4'hF, '0);
      set_ext(1'b0, '0, 2'b00);
      repeat (5) @(negedge clk);  // four busy cycles then the timeout response
      @(negedge clk);
      clear_cmd();
      checks++;
      if (b_error_count !== 8'(n + 1)) begin
        errors++;
        $display("FAIL err_count_timeout %0d: got %0d, expected %0d", n, b_error_count, n + 1);
      end
    end
    set_cmd(1'b0, 1'b1, 1'b0, 1'b1, 8'h84, 4'hF, '0);
    @(negedge clk);
    set_ext(1'b1, 32'h5555AAAA, 2'b00);
    @(negedge clk);
    set_ext(1'b0, '0, 2'b00);
    @(negedge clk);
    clear_cmd();
    checks++;
    if (b_error_count !== 8'd3) begin
      errors++;
      $display("FAIL err_count_final: got %0d, expected 3", b_error_count);
    end
    checks++;
    if (a_error_count !== 8'd0) begin
      errors++;
      $display("FAIL err_count_other: got %0d, expected 0", a_error_count);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_read();
    test_write();
    test_timeout();
    test_ready_vs_timeout();
    test_mid_reset();
    test_ignored();
    test_back_to_back();
`ifdef RGGEN_BUS_EXPORTER_ERROR_COUNT_EN
    test_error_count();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
